// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU command encodings, occupancy states and result entry record
package alu_pkg;

  localparam int ALU_MAX_SIZE = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_NAND = 3'b101;
  localparam logic [2:0] ALU_NOR  = 3'b110;
  localparam logic [2:0] ALU_OR   = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } alu_occ_e;

  // Result is held at the maximum width, zero-extended above the configured size.
  typedef struct packed {
    logic [ALU_MAX_SIZE-1:0] result;
    logic [2:0]              command;
    logic                    carry;
    logic                    overflow;
  } alu_entry_t;

  function automatic logic alu_is_arith(input logic [2:0] cmd);
    return (cmd == ALU_ADD) || (cmd == ALU_SUB) || (cmd == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_result_entry.sv
// rtl/alu_result_entry.sv - one enable-loaded result entry with carry/overflow qualification
module alu_result_entry
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  alu_entry_t d,
  output alu_entry_t q
);

  // Qualification is idempotent, so entries moved from tail to head pass through unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q.result   <= d.result;
      q.command  <= d.command;
      q.carry    <= d.carry & alu_is_arith(d.command);
      q.overflow <= d.overflow & alu_is_arith(d.command);
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - two-entry skid buffer for ALU results; sticky flags with ALU_RESULT_STICKY_EN
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_command,
  input  logic [size-1:0] in_result,
  input  logic            in_carryout,
  input  logic            in_overflow,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] out_result,
  output logic [2:0]      out_command,
  output logic            out_carry,
  output logic            out_overflow,
  output logic            out_zero,
  output logic            out_negative,
  input  logic            clear_sticky,
  output logic            sticky_overflow,
  output logic            sticky_carry
);

  alu_occ_e   state, state_next;
  alu_entry_t in_entry, head_d, head_q, tail_q;
  logic       in_ready_q, out_valid_q;
  logic       push, pop;
  logic       head_load, tail_load, head_from_tail;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    in_entry                  = '0;
    in_entry.result[size-1:0] = in_result;
    in_entry.command          = in_command;
    in_entry.carry            = in_carryout;
    in_entry.overflow         = in_overflow;
  end

  always_comb begin
    state_next     = state;
    head_load      = 1'b0;
    tail_load      = 1'b0;
    head_from_tail = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          head_load  = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_load = 1'b1;
        end else if (push) begin
          state_next = TWO;
          tail_load  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next     = ONE;
          head_load      = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_q  <= (state_next != TWO);
      out_valid_q <= (state_next != EMPTY);
    end
  end

  assign head_d = head_from_tail ? tail_q : in_entry;

  alu_result_entry u_head (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (head_load),
    .d       (head_d),
    .q       (head_q)
  );

  alu_result_entry u_tail (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tail_load),
    .d       (in_entry),
    .q       (tail_q)
  );

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_result   = head_q.result[size-1:0];
  assign out_command  = head_q.command;
  assign out_carry    = head_q.carry;
  assign out_overflow = head_q.overflow;
  assign out_zero     = ~|head_q.result;
  assign out_negative = head_q.result[size-1];

`ifdef ALU_RESULT_STICKY_EN
  logic sticky_ov_q, sticky_cy_q;

  // A set in the same cycle as a clear wins so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_ov_q <= 1'b0;
      sticky_cy_q <= 1'b0;
    end else begin
      sticky_ov_q <= (sticky_ov_q & ~clear_sticky) | (pop & head_q.overflow);
      sticky_cy_q <= (sticky_cy_q & ~clear_sticky) | (pop & head_q.carry);
    end
  end

  assign sticky_overflow = sticky_ov_q;
  assign sticky_carry    = sticky_cy_q;
`else
  logic unused_clear_sticky;
  assign unused_clear_sticky = clear_sticky;
  assign sticky_overflow     = 1'b0;
  assign sticky_carry        = 1'b0;
`endif

endmodule
